array_stream_loader: RTL and testbench

Upstream fill stage for the sum-of-array kernel.
- Accepts a valid/ready data stream and writes n consecutive words into the bram_2p write port at addresses 0..n-1.
- Pulses finish when the last word is committed, so the top level can chain finish into the kernel's start.
- Shares the BRAM with the kernel: loader drives the write port, kernel drives the read port.

---
 rtl/loader_pkg.sv | 19 +
 rtl/array_stream_loader_if.sv | 41 ++++
 rtl/array_stream_loader.sv | 114 +++++++++++
 tb/tb_array_stream_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the array stream loader: FSM state encoding,
// default BRAM geometry and the word type used on the stream/BRAM data path.
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [DATA_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_stream_loader_if.sv
// ---------------------------------------------------------------------------
// array_stream_loader_if
// Bundles the loader's input stream (valid/ready/data) and the BRAM write
// port it drives.
//   master : loader side  - consumes the stream, drives the BRAM write port
//   slave  : environment  - produces the stream, observes the write port
// Parameters: ADDR_W (BRAM address width), DATA_W (word width).
// ---------------------------------------------------------------------------
interface array_stream_loader_if
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              arr_write_en;
    logic [ADDR_W-1:0] arr_write_addr;
    logic [DATA_W-1:0] arr_write_val;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output arr_write_en,
        output arr_write_addr,
        output arr_write_val
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  arr_write_en,
        input  arr_write_addr,
        input  arr_write_val
    );

endinterface

// File: rtl/array_stream_loader.sv
// ---------------------------------------------------------------------------
// array_stream_loader
// Upstream fill stage for the sum-of-array kernel. On an accepted start it
// latches n and writes the next n stream words to BRAM addresses 0..n-1,
// then pulses finish once the last word has been committed.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : begin a load (sampled only in IDLE)
//   n         : element count, latched on accepted start
//   finish    : one-cycle pulse, load complete
//   bus       : array_stream_loader_if.master
//               (in_valid/in_ready/in_data stream,
//                arr_write_en/arr_write_addr/arr_write_val BRAM write port)
//   checksum  : running sum of accepted words mod 2^DATA_W
//               (present only when LOADER_CHECKSUM_EN is defined)
//
// Optional feature macro: LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module array_stream_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     n,
    output logic                  finish,
    array_stream_loader_if.master bus
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     checksum
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n_q;
    logic              handshake;

    // in_ready is a register, so the handshake has no combinational path
    // from in_valid back to in_ready.
    assign handshake = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            bus.in_ready       <= 1'b0;
            finish             <= 1'b0;
            bus.arr_write_en   <= 1'b0;
            bus.arr_write_addr <= '0;
            bus.arr_write_val  <= '0;
            idx                <= '0;
            n_q                <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum           <= '0;
`endif
        end else begin
            finish           <= 1'b0;
            bus.arr_write_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        n_q <= n;
                        idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (n == '0) begin
                            state <= DONE;
                        end else begin
                            state        <= LOAD;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (handshake) begin
                        bus.arr_write_en   <= 1'b1;
                        bus.arr_write_addr <= idx;
                        bus.arr_write_val  <= bus.in_data;
                        idx                <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum + bus.in_data;
`endif
                        // Dropping in_ready here caps acceptance at n_q words.
                        if (idx == n_q - 1'b1) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end

                // The final write strobe is visible during DONE; finish is
                // raised one cycle later so it never precedes the commit.
                DONE: begin
                    state  <= IDLE;
                    finish <= 1'b1;
                end

                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_array_stream_loader
// Randomized scoreboard bench for array_stream_loader. The driver issues
// loads and pushes the expected BRAM image; an independent monitor checks
// writes, write latency, finish timing, over-acceptance and reset values.
// Build with +define+LOADER_CHECKSUM_EN to also check the checksum output.
// ---------------------------------------------------------------------------
module tb_array_stream_loader;
    import loader_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] n;
    logic          finish;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    array_stream_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    array_stream_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n),
        .finish (finish),
        .bus    (bus)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int unsigned addr; int unsigned data; } wr_t;
    typedef struct { int cyc; int unsigned sum; } fin_t;

    // Scoreboard state
    wr_t         wq[$];    // expected writes, in address order (driver pushes)
    int          hsq[$];   // cycle each write is due (one after handshake)
    fin_t        finq[$];  // expected finish pulses
    int          cyc = 0;
    int          load_id = 0;
    int          load_n = 0;
    int unsigned cur_sum = 0;
    int          tmo_cnt = 0;
    bit          end_req = 0;
    int          checks = 0;
    int          passes = 0;
    logic        rst_at_edge;
    int unsigned preset[$];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- Monitor ----------------
    int  seen_id = 0;
    int  hs_cnt  = 0;
    bit  done    = 0;

    always @(negedge clk) begin
        if (rst_at_edge === 1'b0) begin
            chk(bus.in_ready == 1'b0,     "rst_in_ready", bus.in_ready, 0);
            chk(finish == 1'b0,           "rst_finish", finish, 0);
            chk(bus.arr_write_en == 1'b0, "rst_write_en", bus.arr_write_en, 0);
            chk(bus.arr_write_addr == '0, "rst_write_addr", bus.arr_write_addr, 0);
            chk(bus.arr_write_val == '0,  "rst_write_val", bus.arr_write_val, 0);
        end

        if (!rst_n) begin
            wq.delete();
            hsq.delete();
            finq.delete();
            seen_id = load_id;
            hs_cnt  = 0;
        end else begin
            // Writes belong to a handshake from an earlier cycle.
            if (bus.arr_write_en) begin
                if (wq.size() == 0 || hsq.size() == 0) begin
                    chk(1'b0, "unexpected_write", bus.arr_write_addr, -1);
                end else begin
                    wr_t e;
                    int  due;
                    e   = wq.pop_front();
                    due = hsq.pop_front();
                    chk(bus.arr_write_addr == AW'(e.addr), "write_addr", bus.arr_write_addr, e.addr);
                    chk(bus.arr_write_val == e.data, "write_val", bus.arr_write_val, e.data);
                    chk(cyc == due, "write_latency", cyc, due);
                end
            end

            if (finish) begin
                if (finq.size() == 0) begin
                    chk(1'b0, "spurious_finish", cyc, -1);
                end else begin
                    fin_t f;
                    f = finq.pop_front();
                    chk(cyc == f.cyc, "finish_cycle", cyc, f.cyc);
`ifdef LOADER_CHECKSUM_EN
                    chk(checksum == f.sum, "checksum", checksum, f.sum);
`endif
                end
            end else if (finq.size() > 0 && finq[0].cyc <= cyc) begin
                chk(1'b0, "missed_finish", cyc, finq[0].cyc);
                void'(finq.pop_front());
            end

            if (load_id != seen_id) begin
                seen_id = load_id;
                hs_cnt  = 0;
                if (load_n == 0) finq.push_back('{cyc + 2, 0});
            end

            if (bus.in_valid && bus.in_ready) begin
                if (hs_cnt >= load_n) begin
                    chk(1'b0, "over_accept", hs_cnt + 1, load_n);
                end else begin
                    hs_cnt++;
                    hsq.push_back(cyc + 1);
                    if (hs_cnt == load_n) finq.push_back('{cyc + 2, cur_sum});
                end
            end
        end

        if (end_req && !done) begin
            done = 1;
            chk(wq.size() == 0,   "writes_outstanding", wq.size(), 0);
            chk(finq.size() == 0, "finish_outstanding", finq.size(), 0);
            chk(tmo_cnt == 0,     "load_timeout", tmo_cnt, 0);
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    end

    // ---------------- Driver ----------------
    // mode 0: in_valid held high, 1: random, 2: pattern 1,0,0,1,1
    // Called in IDLE or in the finish cycle of the previous load; returns in
    // this load's finish cycle so consecutive calls chain start onto finish.
    task automatic run_load(input int nn, input int mode, input bit busy_start);
        int unsigned words[$];
        int          j, t;
        bit          v;
        bit          pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        words = {};
        for (int i = 0; i < nn; i++)
            words.push_back((preset.size() == nn) ? preset[i] : $urandom);
        preset = {};

        cur_sum = 0;
        foreach (words[i]) begin
            cur_sum += words[i];
            wq.push_back('{i, words[i]});
        end
        load_n = nn;
        load_id++;
        start  = 1'b1;
        n      = AW'(nn);

        @(posedge clk); #1;
        start = 1'b0;
        n     = AW'($urandom);
        j = 0;
        t = 0;
        while (j < nn && t < 4 * nn + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = pat[t % 5];
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? words[j] : $urandom;
            if (busy_start && t == 1) begin
                start = 1'b1;
                n     = AW'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) j++;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        if (j < nn) tmo_cnt++;

        if (nn > 0) begin
            // Offer one more word during DONE; it must not be accepted.
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int j, t;
        rst_n        = 1'b0;
        start        = 1'b0;
        n            = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        preset = {32'd10, 32'd20, 32'd30, 32'd40};
        run_load(4, 0, 0);
        run_load(3, 2, 0);
        run_load(0, 0, 0);
        run_load(6, 1, 1);

        // Reset after three handshakes of an n=8 load.
        cur_sum = 0;
        for (int i = 0; i < 8; i++) wq.push_back('{i, 32'(i) * 32'h0101_0101});
        load_n = 8;
        load_id++;
        start  = 1'b1;
        n      = AW'(8);
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b1;
        j = 0;
        t = 0;
        while (j < 3 && t < 50) begin
            bus.in_data = 32'(j) * 32'h0101_0101;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) j++;
            @(posedge clk); #1;
            t++;
        end
        if (j < 3) tmo_cnt++;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_load(2, 0, 0);
        run_load(5, 0, 0);
        run_load(1023, 1, 0);
        for (int k = 0; k < 4; k++) run_load($urandom_range(0, 12), $urandom_range(0, 2), 0);

        repeat (5) @(posedge clk);
        #1 end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("FAIL end_of_test: monitor did not finish");
        $fatal(1);
    end

endmodule
